// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM states, result width, seven-segment glyphs
// and the double-dabble nibble adjust helper.
package calc_pkg;

    localparam int unsigned RESULT_W = 7;
    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned BCD_W    = 3 * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0010000;

    // Add 3 to a BCD nibble of 5 or more ahead of the shift
    function automatic logic [DIGIT_W-1:0] dabble_adj(input logic [DIGIT_W-1:0] n);
        return (n >= DIGIT_W'(5)) ? n + DIGIT_W'(3) : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment glyph, with forced blank.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = GLYPH_0;
                4'd1:    seg_c = GLYPH_1;
                4'd2:    seg_c = GLYPH_2;
                4'd3:    seg_c = GLYPH_3;
                4'd4:    seg_c = GLYPH_4;
                4'd5:    seg_c = GLYPH_5;
                4'd6:    seg_c = GLYPH_6;
                4'd7:    seg_c = GLYPH_7;
                4'd8:    seg_c = GLYPH_8;
                4'd9:    seg_c = GLYPH_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// ALU result to 3-digit BCD via sequential double-dabble, shown on a multiplexed
// common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module result_display
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RESULT_W-1:0] value,
    output logic                busy,
    output logic                done,
    output logic [DIGIT_W-1:0]  bcd2,
    output logic [DIGIT_W-1:0]  bcd1,
    output logic [DIGIT_W-1:0]  bcd0,
    output logic [SEG_W-1:0]    seg,
    output logic [2:0]          an
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = 3;

    conv_state_t         state, state_n;
    logic [RESULT_W-1:0] sh, sh_n;
    logic [BCD_W-1:0]    scr, scr_n, adj;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [BCD_W-1:0]    bcd, bcd_n;
    logic                busy_n, done_n;

    logic [PRE_W-1:0]    pre, pre_n;
    logic [1:0]          idx, idx_n;
    logic [2:0]          an_n;
    logic [DIGIT_W-1:0]  digit_c;
    logic                blank_c;
    logic [SEG_W-1:0]    seg_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            scr   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            scr   <= scr_n;
            cnt   <= cnt_n;
            bcd   <= bcd_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Conversion next-state and datapath
    always_comb begin
        state_n = state;
        sh_n    = sh;
        scr_n   = scr;
        cnt_n   = cnt;
        bcd_n   = bcd;
        done_n  = 1'b0;
        adj     = {dabble_adj(scr[11:8]), dabble_adj(scr[7:4]), dabble_adj(scr[3:0])};
        case (state)
            IDLE: begin
                if (start) begin
                    sh_n    = value;
                    scr_n   = '0;
                    cnt_n   = CNT_W'(RESULT_W);
                    state_n = CONV;
                end
            end
            CONV: begin
                scr_n = {adj[BCD_W-2:0], sh[RESULT_W-1]};
                sh_n  = {sh[RESULT_W-2:0], 1'b0};
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                bcd_n   = scr;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign bcd2 = bcd[11:8];
    assign bcd1 = bcd[7:4];
    assign bcd0 = bcd[3:0];

    // Scan: next index, and the glyph for the digit it will select
    always_comb begin
        pre_n = pre + PRE_W'(1);
        idx_n = idx;
        if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre_n = '0;
            case (idx)
                2'd0:    idx_n = 2'd1;
                2'd1:    idx_n = 2'd2;
                default: idx_n = 2'd0;
            endcase
        end else if (idx == 2'd3) begin
            idx_n = 2'd0;
        end
        case (idx_n)
            2'd1:    begin an_n = 3'b101; digit_c = bcd_n[7:4];  end
            2'd2:    begin an_n = 3'b011; digit_c = bcd_n[11:8]; end
            default: begin an_n = 3'b110; digit_c = bcd_n[3:0];  end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank_c = ((idx_n == 2'd2) && (bcd_n[11:8] == '0)) ||
                  ((idx_n == 2'd1) && (bcd_n[11:8] == '0) && (bcd_n[7:4] == '0));
`else
        blank_c = 1'b0;
`endif
    end

    seg7_decode u_dec (
        .digit (digit_c),
        .blank (blank_c),
        .seg_c (seg_c)
    );

    // Registered scan outputs so seg and an switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
            an  <= 3'b110;
            seg <= GLYPH_0;
        end else begin
            pre <= pre_n;
            idx <= idx_n;
            an  <= an_n;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display with a short scan period.
module tb_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] value;
    logic       busy, done;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [6:0] seg;
    logic [2:0] an;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD = BL;
`else
    localparam logic [6:0] LEAD = G0;
`endif

    result_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int t1, t2, nd, busy_cnt;
        logic [2:0] prev;

        rst = 1'b1; start = 1'b0; value = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd",  32'({bcd2, bcd1, bcd0}), 32'h000);
        check("rst_an",   32'(an), 32'b110);
        check("rst_seg",  32'(seg), 32'(G0));
        rst = 1'b0;
        @(negedge clk);

        // 127, one-cycle start
        value = 7'd127; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            if (done) nd++;
            @(negedge clk);
        end
        check("127_busy_cycles", 32'(busy_cnt), 32'd8);
        check("127_no_early_done", 32'(nd), 32'd0);
        check("127_done", 32'(done), 32'd1);
        check("127_busy_low", 32'(busy), 32'd0);
        check("127_bcd", 32'({bcd2, bcd1, bcd0}), 32'h127);
        @(negedge clk);
        check("127_done_pulse", 32'(done), 32'd0);
        repeat (2) @(negedge clk);

        // 0 then 99, start held high
        value = 7'd0; start = 1'b1;
        @(negedge clk);
        value = 7'd99;
        wait_done(20, ok);
        check("b2b_done1", 32'(ok), 32'd1);
        t1 = cyc;
        check("b2b_bcd0", 32'({bcd2, bcd1, bcd0}), 32'h000);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_restart", 32'(busy), 32'd1);
        wait_done(20, ok);
        check("b2b_done2", 32'(ok), 32'd1);
        t2 = cyc;
        check("b2b_spacing", 32'(t2 - t1), 32'd9);
        check("b2b_bcd99", 32'({bcd2, bcd1, bcd0}), 32'h099);
        repeat (2) @(negedge clk);

        // start during conversion is ignored
        value = 7'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        value = 7'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, ok);
        check("ign_done", 32'(ok), 32'd1);
        check("ign_bcd", 32'({bcd2, bcd1, bcd0}), 32'h064);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("ign_no_second", 32'(nd), 32'd0);

        // reset three cycles into a conversion of 100
        value = 7'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_bcd", 32'({bcd2, bcd1, bcd0}), 32'h000);
        check("mid_rst_an", 32'(an), 32'b110);
        check("mid_rst_seg", 32'(seg), 32'(G0));
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("mid_rst_no_done", 32'(nd), 32'd0);

        // reset wins over start on the same edge
        rst = 1'b1; start = 1'b1; value = 7'd42;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);

        // convert 5 and watch the scan
        value = 7'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, ok);
        check("scan_done", 32'(ok), 32'd1);
        check("scan_bcd", 32'({bcd2, bcd1, bcd0}), 32'h005);
        ok = 1'b0;
        prev = an;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an == 3'b110 && prev == 3'b011) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
        check("scan_sync", 32'(ok), 32'd1);
        check("scan_u_seg", 32'(seg), 32'(G5));
        repeat (3) @(negedge clk);
        check("scan_u_hold", 32'(an), 32'b110);
        @(negedge clk);
        check("scan_t_an", 32'(an), 32'b101);
        check("scan_t_seg", 32'(seg), 32'(LEAD));
        repeat (4) @(negedge clk);
        check("scan_h_an", 32'(an), 32'b011);
        check("scan_h_seg", 32'(seg), 32'(LEAD));
        repeat (4) @(negedge clk);
        check("scan_wrap_an", 32'(an), 32'b110);
        check("scan_wrap_seg", 32'(seg), 32'(G5));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/result_display.md
# result_display

Downstream stage of the calculator ALU: it captures the 7-bit unsigned ALU result on a start strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It holds the last converted value and time-multiplexes it onto a 3-digit common-anode seven-segment display. The display always shows the last completed conversion and never intermediate values.

## Interface
- SCAN_DIV, 1000: clock cycles per digit-scan step. Legal range is 2 or more.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  capture `value` and begin a conversion. Honoured only when `busy` is 0.
- value  in  7  unsigned ALU result, 0..127.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the BCD registers update.
- bcd2  out  4  hundreds digit (held).
- bcd1  out  4  tens digit (held).
- bcd0  out  4  units digit (held).
- seg  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  out  3  digit enable, active-low, one-hot; an[0] selects units.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, latch `value` into a 7-bit shift register, clear the 12-bit BCD scratch register, load the iteration counter with 7, and go to CONV.
  - CONV: each cycle, add 3 to every scratch nibble that is 5 or more, then shift {scratch, shift register} left by 1 and decrement the counter. After the 7th iteration, go to LOAD.
  - LOAD: copy scratch into bcd2/bcd1/bcd0, pulse `done`, and return to IDLE.
- `start` while `busy` is ignored. It is not queued.
- `start` is level-sampled in IDLE. Holding it high restarts a conversion on the cycle after each `done`.
- Scan logic:
  - A prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0. Index 3 is unreachable; if ever reached, it recovers to 0.
  - `an` is low on the bit for the current index. `seg` is the encoding of the held digit at that index.
  - Scan runs continuously, independent of the FSM.
- Digit encoding: 0..9 use standard glyphs. Nibble values 10..15 are unreachable; any such value drives `seg` = 7'b1111111 (blank).

## Timing
- Reset values:
  - FSM is IDLE; `busy` = 0, `done` = 0.
  - bcd2/bcd1/bcd0 = 0.
  - Prescaler = 0 and digit index = 0, so `an` = 3'b110 and `seg` = 7'b1000000 (glyph 0).
- Latency, with `start` sampled at edge N:
  - `busy` = 1 after edge N.
  - CONV iterations occur at edges N+1..N+7.
  - LOAD occurs at edge N+8: bcd registers update, `done` = 1 and `busy` = 0 for the following cycle.
  - The next `start` can be accepted at edge N+9.
- `bcd*` and `seg` change only at the LOAD edge. The scan picks up new digits at the next index evaluation, with no glitch between digits.
- Reset asserted mid-conversion: on the next edge, return to IDLE with all outputs at their reset values. The partial result is discarded.
- Reset takes priority over `start` on the same edge.
- The digit index advances on the edge where the prescaler wraps from SCAN_DIV-1 to 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - The hundreds digit is blanked (`seg` = 7'b1111111 while it is selected) when bcd2 = 0.
  - The tens digit is blanked when bcd2 = 0 and bcd1 = 0.
  - The units digit is never blanked.
  - `an` scanning is unchanged.
- LEADING_ZERO_BLANK_EN undefined: all three digits are always shown, including leading zeros.

## Structure
- Shared package `calc_pkg` holds:
  - the FSM state enum (IDLE, CONV, LOAD);
  - SEG_BLANK = 7'b1111111;
  - the digit glyph constants;
  - the 7-bit result width constant shared with the ALU.
- Sub-module `seg7_decode`: combinational 4-bit to 7-bit active-low glyph decoder, with a blank input. It is instantiated once, on the muxed digit.

## Test plan
- After reset: `busy` = 0, `done` = 0, bcd = 0/0/0, `an` = 3'b110, `seg` = 7'b1000000.
- `value` = 127 with a 1-cycle `start`: `busy` high for 8 cycles, `done` pulses once, bcd2/bcd1/bcd0 = 1/2/7.
- `value` = 0, then `value` = 99 back to back, with `start` held high: results 0/0/0, then 0/9/9. Each `done` arrives 9 edges after the previous one.
- `start` with `value` = 64, then a second `start` with `value` = 5 pulsed mid-conversion: the second is ignored and the result is 0/6/4.
- `rst` asserted 3 cycles into a conversion of 100: next cycle `busy` = 0, `done` = 0, bcd = 0/0/0. No `done` appears afterwards.
- SCAN_DIV = 4 with bcd = 0/0/5:
  - `an` cycles 110→101→011 every 4 cycles.
  - With LEADING_ZERO_BLANK_EN: `seg` = 7'b0010010 on units and 7'b1111111 on the other two digits.
  - Without it: those two digits show 7'b1000000.
